// File: rtl/dmem_io_arbiter.sv
// Data-memory / IO arbiter: shares one sync RAM between CPU and loader,
// decodes LED/switch IO. Optional macro: DMEM_ARB_ROUND_ROBIN_EN.
//
// Ports:
//   clk, rst (sync, active-high)
//   cpu_req/we/addr/wdata -> cpu_gnt, cpu_rvalid, cpu_rdata
//   ldr_req/addr/wdata    -> ldr_gnt (write-only loader)
//   mem_en/we/addr/wdata, mem_rdata (1-cycle read RAM)
//   sw_in (switches), led_out (registered LEDs)
module dmem_io_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        ldr_req,
  input  logic [13:0] ldr_addr,
  input  logic [31:0] ldr_wdata,
  output logic        ldr_gnt,
  output logic        mem_en,
  output logic        mem_we,
  output logic [13:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out
);

  localparam logic [31:0] LED_ADDR = 32'hFFFF_FC60;
  localparam logic [31:0] SW_ADDR  = 32'hFFFF_FC62;

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t      state;
  logic        rd_io;
  logic [31:0] io_q;
  logic [31:0] rdata_q;
  logic        cpu_is_io;
  logic        cpu_wins;
  logic        idle_ok;

  assign cpu_is_io = (cpu_addr[31:10] == 22'h3FFFFF);
  assign idle_ok   = (state == IDLE) && !rst;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // last_grant: 1 = loader won last, so the CPU goes next
  logic last_grant;
  assign cpu_wins = !ldr_req || last_grant;
`else
  assign cpu_wins = !ldr_req;
`endif

  assign cpu_gnt = idle_ok && cpu_req && cpu_wins;
  assign ldr_gnt = idle_ok && ldr_req && !cpu_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ldr_gnt) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
    end else if (cpu_gnt && !cpu_is_io) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr[15:2];
      mem_wdata = cpu_we ? cpu_wdata : '0;
    end
  end

  // RAM data is only valid in RD_WAIT, so it is passed through there
  // and latched into rdata_q to hold until the next response.
  assign cpu_rvalid = (state == RD_WAIT) && !rst;
  assign cpu_rdata  = (state == RD_WAIT)
                    ? (rd_io ? io_q : mem_rdata)
                    : rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      led_out <= '0;
      rdata_q <= '0;
      io_q    <= '0;
      rd_io   <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_gnt) begin
            if (cpu_is_io && cpu_we && cpu_addr == LED_ADDR)
              led_out <= cpu_wdata[15:0];
            if (!cpu_we) begin
              state <= RD_WAIT;
              rd_io <= cpu_is_io;
              io_q  <= (cpu_is_io && cpu_addr == SW_ADDR)
                     ? {16'b0, sw_in} : '0;
            end
          end
        end
        RD_WAIT: begin
          rdata_q <= cpu_rdata;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      if (cpu_gnt)
        last_grant <= 1'b0;
      else if (ldr_gnt)
        last_grant <= 1'b1;
`endif
    end
  end

endmodule
